ram8_block_mover: RTL and testbench
===================================

Name: ram8_block_mover

Overview:
- Memory-side initiator that drives the address/load/in/out port of an 8-word x 16-bit RAM (ram8-style: combinational read, write on posedge when load=1).
- Performs one block operation per start request:
  - COPY: read src word, write it to dst.
  - FILL: write a constant word to dst.
- Sits between a control source (CPU or test sequencer) and a RAM8 instance; the RAM stays a plain responder.

Parameters:
- ADDR_W, 3, RAM address width; memory depth = 2**ADDR_W.
- DATA_W, 16, word width.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  1  0=COPY, 1=FILL; latched on start.
- src_addr  in  ADDR_W  first source address (COPY only); latched on start.
- dst_addr  in  ADDR_W  first destination address; latched on start.
- count  in  ADDR_W+1  words to transfer, 0..8; latched on start.
- fill_value  in  DATA_W  FILL data; latched on start.
- busy  out  1  high while an operation is in progress (READ/WRITE/VERIFY).
- done  out  1  one-cycle completion pulse.
- mem_address  out  ADDR_W  to RAM address.
- mem_load  out  1  to RAM load.
- mem_in  out  DATA_W  to RAM in.
- mem_out  in  DATA_W  from RAM out (combinational read data).

Behaviour:
- Clocking and reset:
  - One clock: clk.
  - Reset is asynchronous and active-low (rst_n).
  - Reset forces state IDLE, busy=0, done=0, mem_load=0, mem_address=0, mem_in=0, internal data/pointer/remaining registers=0.
- States: IDLE, READ, WRITE, DONE (plus VERIFY when the option is enabled). Outputs are decoded from state and registers.
- IDLE:
  - Outputs: mem_load=0, mem_address=0, busy=0.
  - On start=1 at a posedge: latch all inputs into src_ptr, dst_ptr, remaining, mode_q, data_q.
  - Next state: DONE if count=0; READ if COPY; WRITE if FILL.
- READ:
  - Outputs: mem_address=src_ptr, mem_load=0.
  - At posedge: data_q <= mem_out; go to WRITE.
- WRITE:
  - Outputs: mem_address=dst_ptr, mem_load=1, mem_in=data_q (FILL: data_q holds fill_value).
  - At posedge: remaining--, src_ptr++, dst_ptr++ (mod 2**ADDR_W).
  - Next state: DONE if remaining was 1; else READ (COPY) or WRITE (FILL).
- DONE: done=1, busy=0, mem_load=0 for exactly one cycle, then IDLE.
- Throughput:
  - COPY: 2 cycles/word.
  - FILL: 1 cycle/word.
  - Total latency start->done = 1 + words*(2|1) cycles.
  - count=0 gives done on the cycle after start, with no RAM writes.
- Boundary conditions:
  - start outside IDLE (including DONE) is ignored; latched registers do not change.
  - Pointers wrap 7->0 independently. Count 8 with any start address touches every location once.
  - Overlapping regions are processed strictly ascending, word by word, so the result is deterministic. Example: dst=src+1 propagates src[0] forward.
  - count>8 is out of range; the upper bit is honoured literally but only 8 is legal. Verification does not exercise count>8.
  - mem_load is never high outside WRITE, including during the reset assertion cycle.
  - Reset mid-operation aborts immediately. A partially written block is left in RAM and no done pulse is produced.

Optional Feature:
- Macro: RAM8_MOVER_VERIFY_EN.
- Defined:
  - Each WRITE goes to VERIFY (mem_address=dst_ptr, mem_load=0).
  - At posedge, mem_out is compared to data_q; pointer/remaining update moves from WRITE to VERIFY.
  - Adds output err (1 bit, reset 0). err is sticky-high on any mismatch and cleared on the next accepted start.
  - Adds 1 cycle/word.
- Undefined: no VERIFY state, no err port; timing as above.

Decomposition:
- Package ram8_mover_pkg holds:
  - state encoding constants (IDLE=0, READ=1, WRITE=2, DONE=3, VERIFY=4, 3-bit);
  - MODE_COPY=0, MODE_FILL=1.
- One natural sub-module: ram8_mover_ptr, a loadable wrap-around address counter with load/inc. It is instantiated twice (src, dst).
- FSM and datapath remain in the top.

Test Plan:
- Reset: assert rst_n=0 mid-COPY -> busy=0, done=0, mem_load=0 asynchronously; no done pulse after release; words already written remain.
- COPY: RAM[1..3]=0x1111,0x2222,0x3333; start src=1 dst=5 count=3 -> RAM[5..7] equal those values; done exactly 7 cycles after start; RAM[1..3] unchanged.
- FILL with wrap: dst=6 count=4 fill=0xBEEF -> RAM[6],[7],[0],[1]=0xBEEF, others untouched; mem_load high exactly 4 cycles.
- Edge requests: count=0 -> done next cycle, zero mem_load cycles. Second start pulsed while busy -> ignored; only the first block is moved.
- Overlap: RAM[0..7]=0..7, COPY src=0 dst=1 count=7 -> RAM[1..7] all 0.
- VERIFY_EN: bench RAM model drops one write to address 4 -> err=1 after that VERIFY cycle and stays set; next start clears it.

Source files
------------

// File: rtl/ram8_mover_pkg.sv
// Shared state encoding and mode constants for the RAM8 block mover.
package ram8_mover_pkg;

  // VERIFY only exists when RAM8_MOVER_VERIFY_EN is defined; its code is reserved regardless.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRead   = 3'd1,
    StWrite  = 3'd2,
    StDone   = 3'd3,
    StVerify = 3'd4
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram8_mover_ptr.sv
// Loadable wrap-around address counter; one instance each for source and destination.
module ram8_mover_ptr #(
  parameter int unsigned AddrW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic [AddrW-1:0] load_value_i,
  output logic [AddrW-1:0] ptr_o
);

  logic [AddrW-1:0] ptr_q;

  // Load has priority; increment wraps naturally at 2**AddrW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (load_i) begin
      ptr_q <= load_value_i;
    end else if (inc_i) begin
      ptr_q <= ptr_q + 1'b1;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ram8_block_mover.sv
// Block COPY/FILL initiator driving a ram8-style memory port (combinational read,
// write on posedge with load=1). Optional read-back check after each write is
// enabled with RAM8_MOVER_VERIFY_EN, which also adds the sticky err output.
module ram8_block_mover
  import ram8_mover_pkg::*;
#(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] fill_value,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_load,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
`ifdef RAM8_MOVER_VERIFY_EN
  ,
  output logic              err
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ptr_load, ptr_inc;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  state_e            next_word_st;
`ifdef RAM8_MOVER_VERIFY_EN
  logic              err_q, err_d;
`endif

  ram8_mover_ptr #(
    .AddrW (ADDR_W)
  ) u_src_ptr (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (ptr_load),
    .inc_i        (ptr_inc),
    .load_value_i (src_addr),
    .ptr_o        (src_ptr)
  );

  ram8_mover_ptr #(
    .AddrW (ADDR_W)
  ) u_dst_ptr (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (ptr_load),
    .inc_i        (ptr_inc),
    .load_value_i (dst_addr),
    .ptr_o        (dst_ptr)
  );

  // Where to go once the current word is finished.
  always_comb begin
    if (remaining_q == (ADDR_W + 1)'(1)) begin
      next_word_st = StDone;
    end else if (mode_q == MODE_FILL) begin
      next_word_st = StWrite;
    end else begin
      next_word_st = StRead;
    end
  end

  // Next-state, datapath updates and memory-port outputs decoded from state.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    mode_d      = mode_q;
    data_d      = data_q;
    ptr_load    = 1'b0;
    ptr_inc     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    mem_address = '0;
    mem_load    = 1'b0;
    mem_in      = '0;
`ifdef RAM8_MOVER_VERIFY_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ptr_load    = 1'b1;
          remaining_d = count;
          mode_d      = mode;
          data_d      = fill_value;
`ifdef RAM8_MOVER_VERIFY_EN
          err_d       = 1'b0;
`endif
          if (count == '0) begin
            state_d = StDone;
          end else if (mode == MODE_FILL) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        busy        = 1'b1;
        mem_address = src_ptr;
        data_d      = mem_out;
        state_d     = StWrite;
      end
      StWrite: begin
        busy        = 1'b1;
        mem_address = dst_ptr;
        mem_load    = 1'b1;
        mem_in      = data_q;
`ifdef RAM8_MOVER_VERIFY_EN
        state_d     = StVerify;
`else
        ptr_inc     = 1'b1;
        remaining_d = remaining_q - 1'b1;
        state_d     = next_word_st;
`endif
      end
`ifdef RAM8_MOVER_VERIFY_EN
      StVerify: begin
        busy        = 1'b1;
        mem_address = dst_ptr;
        if (mem_out != data_q) begin
          err_d = 1'b1;
        end
        ptr_inc     = 1'b1;
        remaining_d = remaining_q - 1'b1;
        state_d     = next_word_st;
      end
`endif
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      mode_q      <= MODE_COPY;
      data_q      <= '0;
`ifdef RAM8_MOVER_VERIFY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      mode_q      <= mode_d;
      data_q      <= data_d;
`ifdef RAM8_MOVER_VERIFY_EN
      err_q       <= err_d;
`endif
    end
  end

`ifdef RAM8_MOVER_VERIFY_EN
  assign err = err_q;
`endif

endmodule

// File: tb/tb_ram8_block_mover.sv
// Bench for ram8_block_mover: behavioural RAM plus a word-by-word reference model.
module tb_ram8_block_mover;

`ifdef RAM8_MOVER_VERIFY_EN
  localparam int CopyCyc = 3;
  localparam int FillCyc = 2;
`else
  localparam int CopyCyc = 2;
  localparam int FillCyc = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [2:0]  src_addr;
  logic [2:0]  dst_addr;
  logic [3:0]  count;
  logic [15:0] fill_value;
  logic        busy;
  logic        done;
  logic [2:0]  mem_address;
  logic        mem_load;
  logic [15:0] mem_in;
  logic [15:0] mem_out;
`ifdef RAM8_MOVER_VERIFY_EN
  logic        err;
`endif

  logic [15:0] ram     [8];
  logic [15:0] bd_img  [8];
  logic [15:0] exp_mem [8];
  logic        bd_we = 1'b0;
  logic        drop_en = 1'b0;
  int          total_loads = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  ram8_block_mover dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .count       (count),
    .fill_value  (fill_value),
    .busy        (busy),
    .done        (done),
    .mem_address (mem_address),
    .mem_load    (mem_load),
    .mem_in      (mem_in),
    .mem_out     (mem_out)
`ifdef RAM8_MOVER_VERIFY_EN
    ,
    .err         (err)
`endif
  );

  // RAM8 behaviour: combinational read, posedge write; backdoor image load; optional dropped write.
  assign mem_out = ram[mem_address];
  always @(posedge clk) begin
    if (bd_we) ram <= bd_img;
    else if (mem_load && !(drop_en && mem_address == 3'd4)) ram[mem_address] <= mem_in;
  end

  always @(posedge clk) if (mem_load) total_loads <= total_loads + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_ram();
    @(negedge clk);
    bd_img = exp_mem;
    bd_we  = 1'b1;
    @(negedge clk);
    bd_we  = 1'b0;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 8; i++) exp_mem[i] = 16'($urandom);
  endtask

  // Reference: words processed strictly ascending, addresses wrap mod 8.
  task automatic apply_model(input logic m, input int s, input int d, input int n,
                             input logic [15:0] f);
    for (int i = 0; i < n; i++) begin
      if (m) exp_mem[(d + i) % 8] = f;
      else   exp_mem[(d + i) % 8] = exp_mem[(s + i) % 8];
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_ram%0d", tag, i), 32'(ram[i]), 32'(exp_mem[i]));
  endtask

  // Issue one request; lat = posedges from acceptance edge to first cycle done is seen.
  task automatic run_op(input logic m, input logic [2:0] s, input logic [2:0] d,
                        input logic [3:0] n, input logic [15:0] f, input int extra_at,
                        output int lat, output int loads);
    int l0;
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; count = n; fill_value = f; start = 1'b1;
    l0 = total_loads;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    // Different operands from here on: the accepted ones must stay latched.
    mode = ~m; src_addr = s + 3'd3; dst_addr = d + 3'd2; count = 4'd5; fill_value = ~f;
    while (!done && lat < 200) begin
      if (lat == extra_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    loads = total_loads - l0;
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int lat, loads, n_done;
    logic m;
    logic [2:0] s, d;
    logic [3:0] n;
    logic [15:0] f;

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    count = '0; fill_value = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_load", 32'(mem_load), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_in", 32'(mem_in), 32'd0);
`ifdef RAM8_MOVER_VERIFY_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed COPY src=1 dst=5 count=3.
    for (int i = 0; i < 8; i++) exp_mem[i] = 16'(16'h0100 + i);
    exp_mem[1] = 16'h1111; exp_mem[2] = 16'h2222; exp_mem[3] = 16'h3333;
    load_ram();
    apply_model(1'b0, 1, 5, 3, 16'h0);
    run_op(1'b0, 3'd1, 3'd5, 4'd3, 16'h0, -1, lat, loads);
    check("copy_lat", 32'(lat), 32'(1 + 3 * CopyCyc));
    check("copy_loads", 32'(loads), 32'd3);
    check_mem("copy");

    // FILL with wrap dst=6 count=4.
    randomize_mem();
    load_ram();
    apply_model(1'b1, 0, 6, 4, 16'hBEEF);
    run_op(1'b1, 3'd2, 3'd6, 4'd4, 16'hBEEF, -1, lat, loads);
    check("fill_lat", 32'(lat), 32'(1 + 4 * FillCyc));
    check("fill_loads", 32'(loads), 32'd4);
    check_mem("fill");

    // count=0: done next cycle, no writes.
    run_op(1'b1, 3'd0, 3'd0, 4'd0, 16'hDEAD, -1, lat, loads);
    check("zero_lat", 32'(lat), 32'd1);
    check("zero_loads", 32'(loads), 32'd0);
    check_mem("zero");

    // Second start pulsed while busy is ignored.
    randomize_mem();
    load_ram();
    apply_model(1'b0, 0, 4, 2, 16'h0);
    run_op(1'b0, 3'd0, 3'd4, 4'd2, 16'h0, 2, lat, loads);
    check("busy_start_lat", 32'(lat), 32'(1 + 2 * CopyCyc));
    check("busy_start_loads", 32'(loads), 32'd2);
    check_mem("busy_start");

    // Overlap dst=src+1 propagates word 0 forward.
    for (int i = 0; i < 8; i++) exp_mem[i] = 16'(i);
    load_ram();
    run_op(1'b0, 3'd0, 3'd1, 4'd7, 16'h0, -1, lat, loads);
    for (int i = 0; i < 8; i++) exp_mem[i] = 16'h0;
    check_mem("overlap");

    // Reset during a COPY: async abort, no done, first two words already written stay.
    randomize_mem();
    load_ram();
    @(negedge clk);
    mode = 1'b0; src_addr = 3'd0; dst_addr = 3'd4; count = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("midop_load_before", 32'(mem_load), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midop_busy", 32'(busy), 32'd0);
    check("midop_done", 32'(done), 32'd0);
    check("midop_load", 32'(mem_load), 32'd0);
    check("midop_addr", 32'(mem_address), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("midop_no_done", 32'(n_done), 32'd0);
    apply_model(1'b0, 0, 4, 2, 16'h0);
    check_mem("midop");

    // Randomized operations against the reference model.
    for (int k = 0; k < 20; k++) begin
      randomize_mem();
      load_ram();
      m = 1'($urandom_range(0, 1));
      s = 3'($urandom_range(0, 7));
      d = 3'($urandom_range(0, 7));
      n = 4'($urandom_range(0, 8));
      f = 16'($urandom);
      apply_model(m, int'(s), int'(d), int'(n), f);
      run_op(m, s, d, n, f, -1, lat, loads);
      check($sformatf("rnd%0d_lat", k), 32'(lat),
            32'((n == 0) ? 1 : 1 + int'(n) * (m ? FillCyc : CopyCyc)));
      check($sformatf("rnd%0d_loads", k), 32'(loads), 32'(n));
      check_mem($sformatf("rnd%0d", k));
    end

`ifdef RAM8_MOVER_VERIFY_EN
    // Dropped write to address 4 flags err, which stays set until the next accepted start.
    randomize_mem();
    exp_mem[4] = 16'h0000;
    load_ram();
    drop_en = 1'b1;
    exp_mem[3] = 16'hA5A5; exp_mem[5] = 16'hA5A5;
    run_op(1'b1, 3'd0, 3'd3, 4'd3, 16'hA5A5, -1, lat, loads);
    check("verify_lat", 32'(lat), 32'(1 + 3 * FillCyc));
    check("verify_err_set", 32'(err), 32'd1);
    check_mem("verify");
    repeat (3) @(posedge clk);
    #1;
    check("verify_err_sticky", 32'(err), 32'd1);
    drop_en = 1'b0;
    apply_model(1'b1, 0, 0, 2, 16'h1234);
    run_op(1'b1, 3'd0, 3'd0, 4'd2, 16'h1234, -1, lat, loads);
    check("verify_err_cleared", 32'(err), 32'd0);
    check_mem("verify_clean");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
